// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use stall control for the EX-stage operand muxes.
// Optional FWD_HAZARD_STATS_EN adds saturating stall/forward event counters.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ZERO_FWD = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wreg,
  input  logic              id_load,
  input  logic              ext_stall,
  input  logic              flush,
  output logic              stall_id,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              ex_valid
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]       stat_stall_cnt,
  output logic [31:0]       stat_fwd_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic              wreg;
    logic              load;
    logic [REG_AW-1:0] rd;
  } slot_t;

  // No WB slot is kept: a producer leaving WB has already written the regfile.
  slot_t      ex_q, mem_q, ex_d;
  logic [1:0] fwd_a_d, fwd_b_d;
  logic       issue;

  function automatic logic match(input slot_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.wreg && (s.rd == r) && ((ZERO_FWD != 0) || (r != '0));
  endfunction

  function automatic logic [1:0] fwd_sel(input slot_t ex_s, input slot_t mem_s,
                                         input logic use_x, input logic [REG_AW-1:0] r);
    if (!use_x) return 2'b00;
    if (match(ex_s, r) && !ex_s.load) return 2'b01;
    if (match(mem_s, r)) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    stall_id = id_valid & ~flush & ex_q.load &
               ((id_use_rs & match(ex_q, id_rs)) | (id_use_rt & match(ex_q, id_rt)));
    issue    = id_valid & ~flush & ~stall_id;
    ex_d     = '0;
    fwd_a_d  = 2'b00;
    fwd_b_d  = 2'b00;
    if (issue) begin
      ex_d.valid = 1'b1;
      ex_d.wreg  = id_wreg;
      ex_d.load  = id_load;
      ex_d.rd    = id_rd;
      fwd_a_d    = fwd_sel(ex_q, mem_q, id_use_rs, id_rs);
      fwd_b_d    = fwd_sel(ex_q, mem_q, id_use_rt, id_rt);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_q  <= '0;
      mem_q <= '0;
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else if (!ext_stall) begin
      mem_q <= ex_q;
      ex_q  <= ex_d;
      fwd_a <= fwd_a_d;
      fwd_b <= fwd_b_d;
    end
  end

  assign ex_valid = ex_q.valid;

`ifdef FWD_HAZARD_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_stall_cnt <= '0;
      stat_fwd_cnt   <= '0;
    end else if (!ext_stall) begin
      if (stall_id && (stat_stall_cnt != 32'hFFFF_FFFF)) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
      if (((fwd_a_d != 2'b00) || (fwd_b_d != 2'b00)) && (stat_fwd_cnt != 32'hFFFF_FFFF)) begin
        stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
